// File: rtl/api_rx_filter.sv
// api_rx_filter
// Pulls fixed-length chip result blocks out of an RX FIFO, checks the block
// tag and the nonce-present marker, and forwards only good blocks downstream
// over a valid/ready stream. Rejected blocks are counted and discarded.
//
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   reg_rst            synchronous soft reset, abandons any block in progress
//   rx_fifo_empty      RX FIFO empty flag
//   rx_fifo_rd_en      RX FIFO read strobe (data arrives one cycle later)
//   rx_fifo_dout       RX FIFO read data
//   out_vld/out_rdy    downstream handshake, transfer when both high
//   out_dat/out_last   forwarded word, last flags word BLK_LEN-1
//   nonce_cnt          forwarded blocks (saturating)
//   drop_cnt           blocks without the marker (saturating)
//   tag_err_cnt        blocks with a wrong tag (saturating)
//   last_miner_id      miner id of the most recently forwarded block
module api_rx_filter #(
    parameter int          BLK_LEN = 11,
    parameter logic [31:0] MARK    = 32'hbeafbeaf,
    parameter logic [7:0]  TAG     = 8'h12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_rst,
    input  logic        rx_fifo_empty,
    output logic        rx_fifo_rd_en,
    input  logic [31:0] rx_fifo_dout,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [31:0] out_dat,
    output logic        out_last,
    output logic [15:0] nonce_cnt,
    output logic [15:0] drop_cnt,
    output logic [7:0]  tag_err_cnt,
    output logic [3:0]  last_miner_id
);

    localparam int CW = $clog2(BLK_LEN + 1);
    localparam int IW = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
    localparam logic [CW-1:0] FULL     = CW'(BLK_LEN);
    localparam logic [CW-1:0] LAST_CAP = CW'(BLK_LEN - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(BLK_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        CHECK,
        SEND
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] issued;
    logic [CW-1:0] captured;
    logic [IW-1:0] idx;
    logic          rd_pending;
    logic [31:0]   blk_buf [BLK_LEN];
    logic [31:0]   tag_word;
    logic          can_read;

    assign tag_word = blk_buf[BLK_LEN-1];

    // Reads stop once the whole block has been requested, so the next block
    // is never touched before this one has been checked and sent.
    assign can_read = ~rx_fifo_empty & (issued < FULL) & ~reg_rst;

    // Next-state and output decode.
    always_comb begin
        state_next    = state;
        rx_fifo_rd_en = 1'b0;
        out_vld       = 1'b0;
        out_dat       = '0;
        out_last      = 1'b0;
        case (state)
            IDLE: begin
                rx_fifo_rd_en = can_read;
                if (~rx_fifo_empty && ~reg_rst) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                rx_fifo_rd_en = can_read;
                // The capture of the final word lands on this edge.
                if (rd_pending && captured == LAST_CAP) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (tag_word[15:8] != TAG) begin
                    state_next = IDLE;
                end else if (blk_buf[BLK_LEN-2] == MARK) begin
                    state_next = SEND;
                end else begin
                    state_next = IDLE;
                end
            end
            SEND: begin
                out_vld  = 1'b1;
                out_dat  = blk_buf[idx];
                out_last = (idx == LAST_IDX);
                if (out_rdy && idx == LAST_IDX) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Block storage. A read still in flight when reg_rst hits is dropped
    // here because the capture is suppressed on the soft-reset edge.
    always_ff @(posedge clk) begin
        if (rd_pending && !reg_rst) begin
            blk_buf[captured[IW-1:0]] <= rx_fifo_dout;
        end
    end

    // Control state, indices and statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            issued        <= '0;
            captured      <= '0;
            idx           <= '0;
            rd_pending    <= 1'b0;
            nonce_cnt     <= '0;
            drop_cnt      <= '0;
            tag_err_cnt   <= '0;
            last_miner_id <= '0;
        end else if (reg_rst) begin
            state         <= IDLE;
            issued        <= '0;
            captured      <= '0;
            idx           <= '0;
            rd_pending    <= 1'b0;
            nonce_cnt     <= '0;
            drop_cnt      <= '0;
            tag_err_cnt   <= '0;
            last_miner_id <= '0;
        end else begin
            state      <= state_next;
            rd_pending <= rx_fifo_rd_en;

            if (rx_fifo_rd_en) begin
                issued <= issued + CW'(1);
            end
            if (rd_pending) begin
                captured <= captured + CW'(1);
            end

            if (state == CHECK) begin
                issued   <= '0;
                captured <= '0;
                if (tag_word[15:8] != TAG) begin
                    if (tag_err_cnt != 8'hff) begin
                        tag_err_cnt <= tag_err_cnt + 8'd1;
                    end
                end else if (blk_buf[BLK_LEN-2] != MARK) begin
                    if (drop_cnt != 16'hffff) begin
                        drop_cnt <= drop_cnt + 16'd1;
                    end
                end
            end

            if (state == SEND && out_rdy) begin
                if (idx == LAST_IDX) begin
                    idx           <= '0;
                    last_miner_id <= tag_word[3:0];
                    if (nonce_cnt != 16'hffff) begin
                        nonce_cnt <= nonce_cnt + 16'd1;
                    end
                end else begin
                    idx <= idx + IW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_api_rx_filter.sv
// tb_api_rx_filter
// Self-checking bench for api_rx_filter. An RX FIFO is modelled with a queue.
// Each block handed to the FIFO is also classified by a block-level model
// (tag, marker) that builds the expected output word stream and counter
// values. A negedge compare process checks every transfer, stall stability
// and the absence of FIFO reads while sending; directed scenarios add literal
// checks on counters and cycle latencies.
module tb_api_rx_filter;

    localparam int          BLK_LEN = 11;
    localparam logic [31:0] MARK    = 32'hbeafbeaf;
    localparam logic [7:0]  TAG     = 8'h12;

    typedef logic [BLK_LEN-1:0][31:0] blk_t;

    logic        clk;
    logic        rst;
    logic        reg_rst;
    logic        rx_fifo_empty;
    logic        rx_fifo_rd_en;
    logic [31:0] rx_fifo_dout;
    logic        out_vld;
    logic        out_rdy;
    logic [31:0] out_dat;
    logic        out_last;
    logic [15:0] nonce_cnt;
    logic [15:0] drop_cnt;
    logic [7:0]  tag_err_cnt;
    logic [3:0]  last_miner_id;

    int          n_checks = 0;
    int          n_fail = 0;

    logic [31:0] fifo_q[$];
    logic [32:0] exp_q[$];
    int          exp_ptr = 0;
    int          exp_nonce = 0;
    int          exp_drop = 0;
    int          exp_tag = 0;
    logic [3:0]  exp_miner = 4'h0;

    int          cyc = 0;
    int          rd_log[$];
    int          vld_rise = -1;
    bit          rdy_toggle = 1'b0;

    logic        prev_stall = 1'b0;
    logic [31:0] prev_dat = '0;
    logic        prev_last = 1'b0;

    api_rx_filter #(
        .BLK_LEN (BLK_LEN),
        .MARK    (MARK),
        .TAG     (TAG)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .reg_rst       (reg_rst),
        .rx_fifo_empty (rx_fifo_empty),
        .rx_fifo_rd_en (rx_fifo_rd_en),
        .rx_fifo_dout  (rx_fifo_dout),
        .out_vld       (out_vld),
        .out_rdy       (out_rdy),
        .out_dat       (out_dat),
        .out_last      (out_last),
        .nonce_cnt     (nonce_cnt),
        .drop_cnt      (drop_cnt),
        .tag_err_cnt   (tag_err_cnt),
        .last_miner_id (last_miner_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    // Block-level reference: decide the fate of a whole block from its tag
    // and marker words and record the expected downstream effect.
    task automatic model_block(input blk_t b);
        if (b[BLK_LEN-1][15:8] != TAG) begin
            if (exp_tag < 255) exp_tag++;
        end else if (b[BLK_LEN-2] == MARK) begin
            for (int i = 0; i < BLK_LEN; i++) begin
                exp_q.push_back({(i == BLK_LEN - 1), b[i]});
            end
            if (exp_nonce < 65535) exp_nonce++;
            exp_miner = b[BLK_LEN-1][3:0];
        end else begin
            if (exp_drop < 65535) exp_drop++;
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        rx_fifo_empty = 1'b0;
    endtask

    task automatic make_block(input logic [31:0] base, input logic [31:0] w9,
                              input logic [31:0] w10, output blk_t b);
        for (int i = 0; i < BLK_LEN - 2; i++) begin
            b[i] = base + 32'(i);
        end
        b[BLK_LEN-2] = w9;
        b[BLK_LEN-1] = w10;
    endtask

    task automatic applyStimulus(input blk_t b);
        model_block(b);
        for (int i = 0; i < BLK_LEN; i++) push_word(b[i]);
    endtask

    // One clock cycle: FIFO read strobe sampled mid-cycle, FIFO data
    // presented just after the edge that accepted the read.
    task automatic step();
        logic pop;
        @(negedge clk);
        pop = rx_fifo_rd_en;
        if (pop) rd_log.push_back(cyc);
        if (out_vld && vld_rise < 0) vld_rise = cyc;
        @(posedge clk);
        #1;
        cyc++;
        if (pop) begin
            checkOutput("fifo_underflow", 32'(fifo_q.size() == 0), 32'd0);
            if (fifo_q.size() != 0) rx_fifo_dout = fifo_q.pop_front();
        end
        rx_fifo_empty = (fifo_q.size() == 0);
        if (rdy_toggle) out_rdy = ~out_rdy;
    endtask

    task automatic wait_quiet(input int limit);
        int quiet = 0;
        int n = 0;
        while (quiet < 5 && n < limit) begin
            step();
            n++;
            if (fifo_q.size() == 0 && !out_vld) quiet++;
            else quiet = 0;
        end
        checkOutput("quiet_timeout", 32'(quiet >= 5), 32'd1);
        checkOutput("all_words_out", 32'(exp_ptr), 32'(exp_q.size()));
    endtask

    task automatic check_counts(input string tag);
        checkOutput({tag, "_nonce"}, 32'(nonce_cnt), 32'(exp_nonce));
        checkOutput({tag, "_drop"}, 32'(drop_cnt), 32'(exp_drop));
        checkOutput({tag, "_tagerr"}, 32'(tag_err_cnt), 32'(exp_tag));
        checkOutput({tag, "_miner"}, 32'(last_miner_id), 32'(exp_miner));
    endtask

    // Compare process: every transfer against the expected stream, stalled
    // outputs must hold, and the FIFO must not be read while sending.
    always @(negedge clk) begin
        if (!rst && !reg_rst) begin
            if (prev_stall) begin
                checkOutput("stall_vld", 32'(out_vld), 32'd1);
                checkOutput("stall_dat", out_dat, prev_dat);
                checkOutput("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (out_vld) begin
                checkOutput("read_in_send", 32'(rx_fifo_rd_en), 32'd0);
            end
            if (out_vld && out_rdy) begin
                if (exp_ptr >= exp_q.size()) begin
                    checkOutput("unexpected_word", out_dat, 32'hdead_0000);
                end else begin
                    checkOutput("out_dat", out_dat, exp_q[exp_ptr][31:0]);
                    checkOutput("out_last", 32'(out_last), 32'(exp_q[exp_ptr][32]));
                    exp_ptr <= exp_ptr + 1;
                end
            end
        end
        prev_stall <= out_vld && !out_rdy;
        prev_dat   <= out_dat;
        prev_last  <= out_last;
    end

    initial begin
        blk_t b;
        blk_t b2;
        int   n;

        rst           = 1'b1;
        reg_rst       = 1'b0;
        out_rdy       = 1'b1;
        rx_fifo_empty = 1'b1;
        rx_fifo_dout  = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        checkOutput("rst_vld", 32'(out_vld), 32'd0);
        checkOutput("rst_last", 32'(out_last), 32'd0);
        checkOutput("rst_dat", out_dat, 32'd0);
        checkOutput("rst_rd_en", 32'(rx_fifo_rd_en), 32'd0);
        checkOutput("rst_nonce", 32'(nonce_cnt), 32'd0);
        checkOutput("rst_drop", 32'(drop_cnt), 32'd0);
        checkOutput("rst_tagerr", 32'(tag_err_cnt), 32'd0);
        checkOutput("rst_miner", 32'(last_miner_id), 32'd0);
        rst = 1'b0;
        step();
        step();

        // Good block, continuous ready: order, latency, counters
        rd_log.delete();
        vld_rise = -1;
        make_block(32'ha000_0000, MARK, 32'h0000_1203, b);
        applyStimulus(b);
        wait_quiet(200);
        check_counts("s1");
        checkOutput("s1_nonce_lit", 32'(nonce_cnt), 32'd1);
        checkOutput("s1_miner_lit", 32'(last_miner_id), 32'd3);
        checkOutput("s1_reads", 32'(rd_log.size()), 32'd11);
        if (rd_log.size() > 0) begin
            checkOutput("s1_vld_latency", 32'(vld_rise - rd_log[0]), 32'd13);
        end

        // Dropped block (no marker) followed directly by a good block
        rd_log.delete();
        vld_rise = -1;
        make_block(32'hb000_0000, 32'h0, 32'h0000_1205, b);
        make_block(32'hb100_0000, MARK, 32'h0000_120a, b2);
        applyStimulus(b);
        applyStimulus(b2);
        wait_quiet(200);
        check_counts("s2");
        checkOutput("s2_drop_lit", 32'(drop_cnt), 32'd1);
        checkOutput("s2_nonce_lit", 32'(nonce_cnt), 32'd2);
        checkOutput("s2_reads", 32'(rd_log.size()), 32'd22);
        if (rd_log.size() >= 22) begin
            checkOutput("s2_burst", 32'(rd_log[10] - rd_log[0]), 32'd10);
            checkOutput("s2_next_read", 32'(rd_log[11] - rd_log[0]), 32'd13);
            checkOutput("s2_vld_latency", 32'(vld_rise - rd_log[11]), 32'd13);
        end

        // Tag mismatch with a valid marker
        make_block(32'hc000_0000, MARK, 32'h0000_3401, b);
        applyStimulus(b);
        wait_quiet(200);
        check_counts("s3");
        checkOutput("s3_tagerr_lit", 32'(tag_err_cnt), 32'd1);
        checkOutput("s3_nonce_lit", 32'(nonce_cnt), 32'd2);

        // Two good blocks with ready toggling every cycle
        out_rdy    = 1'b0;
        rdy_toggle = 1'b1;
        make_block(32'hd000_0000, MARK, 32'h0000_1205, b);
        make_block(32'hd100_0000, MARK, 32'h0000_1206, b2);
        applyStimulus(b);
        applyStimulus(b2);
        wait_quiet(400);
        rdy_toggle = 1'b0;
        out_rdy    = 1'b1;
        check_counts("s4");
        checkOutput("s4_nonce_lit", 32'(nonce_cnt), 32'd4);
        checkOutput("s4_miner_lit", 32'(last_miner_id), 32'd6);

        // FIFO runs dry after 5 words and is refilled 10 cycles later
        make_block(32'he000_0000, MARK, 32'h0000_1207, b);
        model_block(b);
        for (int i = 0; i < 5; i++) push_word(b[i]);
        n = 0;
        while (fifo_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        checkOutput("s5_drain", 32'(fifo_q.size()), 32'd0);
        repeat (10) step();
        checkOutput("s5_gap_vld", 32'(out_vld), 32'd0);
        for (int i = 5; i < BLK_LEN; i++) push_word(b[i]);
        wait_quiet(200);
        check_counts("s5");
        checkOutput("s5_nonce_lit", 32'(nonce_cnt), 32'd5);
        checkOutput("s5_miner_lit", 32'(last_miner_id), 32'd7);

        // Soft reset mid-fill with one read in flight, then a fresh block
        rd_log.delete();
        make_block(32'hf000_0000, MARK, 32'h0000_120c, b);
        for (int i = 0; i < BLK_LEN; i++) push_word(b[i]);
        n = 0;
        while (rd_log.size() < 7 && n < 50) begin
            step();
            n++;
        end
        checkOutput("s6_reads_before", 32'(rd_log.size()), 32'd7);
        reg_rst = 1'b1;
        fifo_q.delete();
        rx_fifo_empty = 1'b1;
        step();
        reg_rst   = 1'b0;
        exp_nonce = 0;
        exp_drop  = 0;
        exp_tag   = 0;
        exp_miner = 4'h0;
        checkOutput("s6_nonce_zero", 32'(nonce_cnt), 32'd0);
        checkOutput("s6_drop_zero", 32'(drop_cnt), 32'd0);
        checkOutput("s6_tagerr_zero", 32'(tag_err_cnt), 32'd0);
        checkOutput("s6_miner_zero", 32'(last_miner_id), 32'd0);
        checkOutput("s6_vld_zero", 32'(out_vld), 32'd0);
        make_block(32'h6000_0000, MARK, 32'h0000_1209, b);
        applyStimulus(b);
        wait_quiet(200);
        check_counts("s6");
        checkOutput("s6_nonce_lit", 32'(nonce_cnt), 32'd1);
        checkOutput("s6_miner_lit", 32'(last_miner_id), 32'd9);

        // Tag error counter saturation
        for (int k = 0; k < 256; k++) begin
            make_block(32'h7000_0000 + 32'(k << 8), MARK, 32'h0000_7701, b);
            applyStimulus(b);
        end
        wait_quiet(6000);
        check_counts("s7");
        checkOutput("s7_tagerr_sat", 32'(tag_err_cnt), 32'h0000_00ff);
        checkOutput("s7_nonce_lit", 32'(nonce_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
